uart_rx_mmio: RTL and testbench
===============================

# uart_rx_mmio

Memory-mapped UART receiver for `little_computer`: the CPU-side counterpart to the existing `uart_tx` MMIO path. It oversamples the GPIO `rx` line at 16x, deframes 8N1 bytes and buffers them in a small FIFO. The CPU drains the FIFO through two 16-bit registers, a data register and a status/control register. It shares the system clock with the rest of the design and sits on the same MMIO decode as `uart_tx`.

## Interface
- `CLKS_PER_SAMPLE`, 325, system clocks per 1/16 bit period (50 MHz → 9615 baud).
- `FIFO_AW`, 3, FIFO address width; depth = 2^FIFO_AW, legal range 1..7.
- `clk`  in  1  system clock, all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `rx`  in  1  asynchronous serial input, idle high.
- `reg_addr`  in  1  0 = DATA, 1 = STATUS.
- `rd_en`  in  1  register read strobe, one clk per access.
- `wr_en`  in  1  register write strobe, one clk per access.
- `wr_data`  in  16  write data; used only for STATUS.
- `rd_data`  out  16  registered read data.
- `rx_avail`  out  1  high while FIFO count ≠ 0; usable as a level interrupt.

## Operation
- `rx` passes through a 2-flop synchronizer (both flops reset to 1) to give `rx_s`; all framing logic uses `rx_s`.
- Prescaler counts 0..CLKS_PER_SAMPLE-1 and emits `tick` on the terminal count. Tick counter is 4 bits. Both counters are held at 0 in IDLE and BREAK.
- FSM states:
  - IDLE: on `rx_s`=0 → START.
  - START: on the 8th tick, if `rx_s`=0 → DATA with bit index 0, else → IDLE (glitch, no effect).
  - DATA: every 16th tick, shift `rx_s` in LSB-first. After bit 7 → STOP.
  - STOP: on the 16th tick, if `rx_s`=1, push the byte and → IDLE. If `rx_s`=0, set `frame_err`, discard the byte and → BREAK.
  - BREAK: wait for `rx_s`=1, then → IDLE.
- Push when the FIFO is full and there is no same-cycle pop: byte dropped, `overrun` set, FIFO contents unchanged.
- DATA read (`rd_en`, `reg_addr`=0):
  - FIFO non-empty: `rd_data` ← {8'h00, head byte}, and the head is popped.
  - FIFO empty: `rd_data` ← 16'h8000, no pop.
- STATUS read (`rd_en`, `reg_addr`=1): `rd_data` ← {overrun, frame_err, 5'b0, full, count[7:0]}, where `full` = (count = depth). No side effects.
- STATUS write (`wr_en`, `reg_addr`=1): write-1-to-clear. `wr_data[15]` clears `overrun`, `wr_data[14]` clears `frame_err`.
- DATA write: ignored.
- `rd_en` and `wr_en` asserted together: both are serviced. The read returns the pre-write value.
- Simultaneous push and pop: both occur, count unchanged. This holds when full (push accepted, no overrun) and when count = 1.
- Flag set and W1C clear in the same cycle: set wins.
- Count arithmetic: 8-bit, range 0..2^FIFO_AW. Read and write pointers are FIFO_AW bits and wrap modulo depth.

## Timing
- Reset values: `rd_data`=16'h0000, `rx_avail`=0, FSM=IDLE, count=0, pointers=0, `overrun`=`frame_err`=0, shift register=0.
- Reset asserted mid-frame aborts the frame: the partial byte is discarded and the FIFO is emptied.
- Read latency: `rd_data` is valid on the clk edge after `rd_en`. It holds until the next read or reset.
- Pop takes effect on that same edge, so back-to-back DATA reads on consecutive clks return successive bytes.
- Push: FIFO count increments on the clk edge after the stop-sample tick. `rx_avail` rises on that same edge.
- End to end, from the `rx` falling start edge to the byte visible in the FIFO: (8 + 16·9)·CLKS_PER_SAMPLE + 4 clks ±1 CLKS_PER_SAMPLE. This is 49404 clks at the default parameters.
- A new start bit is accepted the clk after returning to IDLE, which allows back-to-back frames with a single stop bit.

## Test plan
- Single byte: drive 0x74 at 9615 baud → after the frame, STATUS = 16'h0001 and `rx_avail`=1. DATA read → 16'h0074, then STATUS = 16'h0000 and `rx_avail`=0.
- Empty read after reset: DATA read → 16'h8000, count stays 0, no pointer movement.
- Glitch and framing: a 4-tick low pulse → no byte, FSM back in IDLE. A frame 0x55 with stop=0 → STATUS = 16'h4000 and no push. Write 16'h4000 → STATUS = 16'h0000.
- Overflow: send depth+1 bytes 0x01..0x09 with no reads → STATUS = 16'h8108 (`overrun`, `full`, count 8). Eight DATA reads → 0x0001..0x0008, then a read → 16'h8000.
- Concurrency:
  - Pop on the exact push cycle while full → count stays 8, `overrun` stays 0.
  - W1C of `overrun` on the cycle a new overrun occurs → `overrun` stays 1.
- Reset mid-frame: assert `rst` during data bit 3 of 0xA5 → all outputs at reset values. The next clean frame 0x3C is received correctly.

Source files
------------

// File: rtl/uart_rx_mmio.sv
// uart_rx_mmio: 16x oversampling 8N1 UART receiver with a byte FIFO that the
// CPU drains through a DATA register (pop on read) and a STATUS/control
// register (sticky overrun / framing-error flags, write-1-to-clear).
`timescale 1ns/1ps
module uart_rx_mmio #(
   parameter int CLKS_PER_SAMPLE = 325,
   parameter int FIFO_AW         = 3
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        rx,
   input  logic        reg_addr,
   input  logic        rd_en,
   input  logic        wr_en,
   input  logic [15:0] wr_data,
   output logic [15:0] rd_data,
   output logic        rx_avail
);

   localparam int PW = (CLKS_PER_SAMPLE > 1) ? $clog2(CLKS_PER_SAMPLE) : 1;
   localparam logic [PW-1:0] PRESC_MAX = PW'(CLKS_PER_SAMPLE - 1);
   localparam int DEPTH = 1 << FIFO_AW;
   localparam logic [7:0] DEPTH_CNT = 8'(DEPTH);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP,
      S_BREAK
   } state_t;

   state_t state_q, state_d;
   logic rxMeta_q, rxSync_q;
   logic [PW-1:0] presc_q, presc_d;
   logic [3:0] tickCnt_q, tickCnt_d;
   logic [2:0] bitIdx_q, bitIdx_d;
   logic [7:0] shift_q, shift_d;
   logic tick;
   logic pushReq;
   logic frameErrSet;

   logic [7:0] mem_q [DEPTH];
   logic [FIFO_AW-1:0] wrPtr_q, rdPtr_q;
   logic [7:0] count_q;
   logic overrun_q, frameErr_q;
   logic [15:0] rdData_q;
   logic pop, full, pushAccept, overrunSet;
   logic overrunClr, frameErrClr;

   // Only the two W1C bits of a STATUS write carry meaning.
   logic unusedWrBits;
   assign unusedWrBits = ^wr_data[13:0];

   // Two-flop synchronizer; idles high so reset never looks like a start bit.
   always_ff @(posedge clk) begin
      if (rst) begin
         rxMeta_q <= 1'b1;
         rxSync_q <= 1'b1;
      end else begin
         rxMeta_q <= rx;
         rxSync_q <= rxMeta_q;
      end
   end

   assign tick = (presc_q == PRESC_MAX);

   // Receiver state, prescaler, tick counter, bit index and shift register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         presc_q   <= '0;
         tickCnt_q <= '0;
         bitIdx_q  <= '0;
         shift_q   <= '0;
      end else begin
         state_q   <= state_d;
         presc_q   <= presc_d;
         tickCnt_q <= tickCnt_d;
         bitIdx_q  <= bitIdx_d;
         shift_q   <= shift_d;
      end
   end

   // Framing: counters run only while a frame is in flight; sample mid-bit.
   always_comb begin
      state_d     = state_q;
      presc_d     = presc_q;
      tickCnt_d   = tickCnt_q;
      bitIdx_d    = bitIdx_q;
      shift_d     = shift_q;
      pushReq     = 1'b0;
      frameErrSet = 1'b0;
      if (state_q != S_IDLE && state_q != S_BREAK) begin
         presc_d = tick ? '0 : presc_q + PW'(1);
         if (tick) begin
            tickCnt_d = tickCnt_q + 4'd1;
         end
      end
      case (state_q)
         S_IDLE: begin
            presc_d   = '0;
            tickCnt_d = '0;
            if (!rxSync_q) begin
               state_d = S_START;
            end
         end
         S_START: begin
            if (tick && tickCnt_q == 4'd7) begin
               if (!rxSync_q) begin
                  state_d   = S_DATA;
                  bitIdx_d  = '0;
                  tickCnt_d = '0;
               end else begin
                  state_d = S_IDLE;
               end
            end
         end
         S_DATA: begin
            if (tick && tickCnt_q == 4'd15) begin
               shift_d  = {rxSync_q, shift_q[7:1]};
               bitIdx_d = bitIdx_q + 3'd1;
               if (bitIdx_q == 3'd7) begin
                  state_d = S_STOP;
               end
            end
         end
         S_STOP: begin
            if (tick && tickCnt_q == 4'd15) begin
               if (rxSync_q) begin
                  pushReq = 1'b1;
                  state_d = S_IDLE;
               end else begin
                  frameErrSet = 1'b1;
                  state_d     = S_BREAK;
               end
            end
         end
         S_BREAK: begin
            presc_d   = '0;
            tickCnt_d = '0;
            if (rxSync_q) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // FIFO handshake: a pop in the same cycle frees the slot a full push needs.
   always_comb begin
      pop         = rd_en && !reg_addr && (count_q != 8'd0);
      full        = (count_q == DEPTH_CNT);
      pushAccept  = pushReq && (!full || pop);
      overrunSet  = pushReq && full && !pop;
      overrunClr  = wr_en && reg_addr && wr_data[15];
      frameErrClr = wr_en && reg_addr && wr_data[14];
   end

   // Byte storage; contents need no reset because count gates visibility.
   always_ff @(posedge clk) begin
      if (pushAccept) begin
         mem_q[wrPtr_q] <= shift_q;
      end
   end

   // Pointers and occupancy count; pointers wrap naturally at the depth.
   always_ff @(posedge clk) begin
      if (rst) begin
         wrPtr_q <= '0;
         rdPtr_q <= '0;
         count_q <= '0;
      end else begin
         if (pushAccept) begin
            wrPtr_q <= wrPtr_q + FIFO_AW'(1);
         end
         if (pop) begin
            rdPtr_q <= rdPtr_q + FIFO_AW'(1);
         end
         count_q <= count_q + 8'(pushAccept) - 8'(pop);
      end
   end

   // Sticky error flags; a new event outranks a same-cycle clear.
   always_ff @(posedge clk) begin
      if (rst) begin
         overrun_q  <= 1'b0;
         frameErr_q <= 1'b0;
      end else begin
         if (overrunSet) begin
            overrun_q <= 1'b1;
         end else if (overrunClr) begin
            overrun_q <= 1'b0;
         end
         if (frameErrSet) begin
            frameErr_q <= 1'b1;
         end else if (frameErrClr) begin
            frameErr_q <= 1'b0;
         end
      end
   end

   // Registered read port; reflects state before any same-cycle write or pop.
   always_ff @(posedge clk) begin
      if (rst) begin
         rdData_q <= 16'h0000;
      end else if (rd_en) begin
         if (!reg_addr) begin
            rdData_q <= (count_q != 8'd0) ? {8'h00, mem_q[rdPtr_q]} : 16'h8000;
         end else begin
            rdData_q <= {overrun_q, frameErr_q, 5'b00000, full, count_q};
         end
      end
   end

   assign rd_data  = rdData_q;
   assign rx_avail = (count_q != 8'd0);

endmodule

// File: tb/tb_uart_rx_mmio.sv
// tb_uart_rx_mmio: directed frames into uart_rx_mmio with a read-data
// scoreboard; a monitor pops the expected value whenever a read returns.
`timescale 1ns/1ps
module tb_uart_rx_mmio;

   localparam int CPS      = 4;
   localparam int AW       = 3;
   localparam int BIT_CLKS = 16 * CPS;
   // Edges from the one that drives the start bit low to the one that pushes
   // the byte: 3 edges of sync/idle detect, then 152 sample ticks.
   localparam int PUSH_EDGE = 3 + CPS * (8 + 16 * 9);

   logic        clk = 1'b0;
   logic        rst;
   logic        rx;
   logic        reg_addr;
   logic        rd_en;
   logic        wr_en;
   logic [15:0] wr_data;
   logic [15:0] rd_data;
   logic        rx_avail;

   int checks   = 0;
   int failures = 0;
   logic [15:0] expQ [$];
   logic rdSeen = 1'b0;

   uart_rx_mmio #(
      .CLKS_PER_SAMPLE(CPS),
      .FIFO_AW(AW)
   ) dut (
      .clk(clk),
      .rst(rst),
      .rx(rx),
      .reg_addr(reg_addr),
      .rd_en(rd_en),
      .wr_en(wr_en),
      .wr_data(wr_data),
      .rd_data(rd_data),
      .rx_avail(rx_avail)
   );

   always #5 clk = ~clk;

   // Single comparison point; every check goes through here.
   task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Remember that a read was issued so its result is checked next negedge.
   always @(posedge clk) begin
      rdSeen <= rd_en && !rst;
   end

   // Monitor: every returned read is matched against the scoreboard head.
   always @(negedge clk) begin
      if (rdSeen) begin
         if (expQ.size() == 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL unexpected_read: got %h, expected no read", rd_data);
         end else begin
            checkOutput("rd_data", rd_data, expQ.pop_front());
         end
      end
   end

   // One-cycle register access.
   task automatic applyStimulus(input logic rd, input logic wr, input logic addr, input logic [15:0] data);
      @(posedge clk); #1;
      rd_en    = rd;
      wr_en    = wr;
      reg_addr = addr;
      wr_data  = data;
      @(posedge clk); #1;
      rd_en    = 1'b0;
      wr_en    = 1'b0;
      wr_data  = 16'h0000;
   endtask

   task automatic readReg(input logic addr, input logic [15:0] exp);
      expQ.push_back(exp);
      applyStimulus(1'b1, 1'b0, addr, 16'h0000);
   endtask

   task automatic writeStatus(input logic [15:0] data);
      applyStimulus(1'b0, 1'b1, 1'b1, data);
   endtask

   // Back-to-back DATA reads of n successive bytes, optionally one more on empty.
   task automatic readDataSeq(input int n, input logic [7:0] first, input bit thenEmpty);
      logic [7:0] b;
      @(posedge clk); #1;
      rd_en    = 1'b1;
      reg_addr = 1'b0;
      for (int i = 0; i < n; i++) begin
         b = first + 8'(i);
         expQ.push_back({8'h00, b});
         @(posedge clk); #1;
      end
      if (thenEmpty) begin
         expQ.push_back(16'h8000);
         @(posedge clk); #1;
      end
      rd_en = 1'b0;
   endtask

   task automatic sendFrame(input logic [7:0] data, input logic stopBit);
      @(posedge clk); #1;
      rx = 1'b0;
      repeat (BIT_CLKS) @(posedge clk);
      for (int i = 0; i < 8; i++) begin
         #1 rx = data[i];
         repeat (BIT_CLKS) @(posedge clk);
      end
      #1 rx = stopBit;
      repeat (BIT_CLKS) @(posedge clk);
      #1 rx = 1'b1;
   endtask

   // Send a frame and hit the register port in exactly the cycle of its push.
   task automatic sendAndPoke(input logic [7:0] data, input bit doWrite, input logic [15:0] expRead);
      fork
         sendFrame(data, 1'b1);
         begin
            repeat (PUSH_EDGE) @(posedge clk);
            #1;
            if (doWrite) begin
               wr_en    = 1'b1;
               reg_addr = 1'b1;
               wr_data  = 16'h8000;
            end else begin
               expQ.push_back(expRead);
               rd_en    = 1'b1;
               reg_addr = 1'b0;
            end
            @(posedge clk); #1;
            rd_en   = 1'b0;
            wr_en   = 1'b0;
            wr_data = 16'h0000;
         end
      join
   endtask

   // Watchdog so a wedged run still reports and ends.
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      rst      = 1'b1;
      rx       = 1'b1;
      rd_en    = 1'b0;
      wr_en    = 1'b0;
      reg_addr = 1'b0;
      wr_data  = 16'h0000;
      repeat (4) @(posedge clk);
      #1;
      checkOutput("reset_rd_data", rd_data, 16'h0000);
      checkOutput("reset_rx_avail", {15'b0, rx_avail}, 16'h0000);
      rst = 1'b0;

      // Empty FIFO read
      readReg(1'b0, 16'h8000);
      readReg(1'b1, 16'h0000);
      checkOutput("empty_rx_avail", {15'b0, rx_avail}, 16'h0000);

      // Single byte
      sendFrame(8'h74, 1'b1);
      readReg(1'b1, 16'h0001);
      checkOutput("single_rx_avail", {15'b0, rx_avail}, 16'h0001);
      readReg(1'b0, 16'h0074);
      readReg(1'b1, 16'h0000);
      checkOutput("single_drained_avail", {15'b0, rx_avail}, 16'h0000);

      // Short glitch, then a clean frame proves the receiver is back in idle
      @(posedge clk); #1;
      rx = 1'b0;
      repeat (4 * CPS) @(posedge clk);
      #1 rx = 1'b1;
      repeat (2 * BIT_CLKS) @(posedge clk);
      readReg(1'b1, 16'h0000);
      sendFrame(8'hC3, 1'b1);
      readReg(1'b0, 16'h00C3);

      // Framing error
      sendFrame(8'h55, 1'b0);
      repeat (8) @(posedge clk);
      readReg(1'b1, 16'h4000);
      checkOutput("frame_err_no_push", {15'b0, rx_avail}, 16'h0000);
      writeStatus(16'h4000);
      readReg(1'b1, 16'h0000);

      // Overflow
      for (int b = 1; b <= 9; b++) begin
         sendFrame(8'(b), 1'b1);
      end
      readReg(1'b1, 16'h8108);
      readDataSeq(8, 8'h01, 1'b1);
      writeStatus(16'h8000);
      readReg(1'b1, 16'h0000);

      // Pop on the push cycle while full
      for (int b = 16; b < 24; b++) begin
         sendFrame(8'(b), 1'b1);
      end
      readReg(1'b1, 16'h0108);
      sendAndPoke(8'h18, 1'b0, 16'h0010);
      readReg(1'b1, 16'h0108);
      readDataSeq(8, 8'h11, 1'b1);

      // Push and pop together with a single byte stored
      sendFrame(8'h30, 1'b1);
      sendAndPoke(8'h31, 1'b0, 16'h0030);
      readReg(1'b1, 16'h0001);
      readReg(1'b0, 16'h0031);

      // Overrun clear racing a new overrun
      for (int b = 32; b < 40; b++) begin
         sendFrame(8'(b), 1'b1);
      end
      sendAndPoke(8'h28, 1'b1, 16'h0000);
      readReg(1'b1, 16'h8108);
      writeStatus(16'h8000);
      readReg(1'b1, 16'h0108);
      readDataSeq(8, 8'h20, 1'b1);

      // Reset in the middle of data bit 3 of 0xA5
      sendFrame(8'h99, 1'b1);
      readReg(1'b1, 16'h0001);
      @(posedge clk); #1;
      rx = 1'b0;
      repeat (BIT_CLKS) @(posedge clk);
      #1 rx = 1'b1;
      repeat (BIT_CLKS) @(posedge clk);
      #1 rx = 1'b0;
      repeat (BIT_CLKS) @(posedge clk);
      #1 rx = 1'b1;
      repeat (BIT_CLKS) @(posedge clk);
      #1 rx = 1'b0;
      repeat (20) @(posedge clk);
      #1;
      rst = 1'b1;
      rx  = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      checkOutput("midreset_rd_data", rd_data, 16'h0000);
      checkOutput("midreset_rx_avail", {15'b0, rx_avail}, 16'h0000);
      readReg(1'b1, 16'h0000);
      sendFrame(8'h3C, 1'b1);
      readReg(1'b0, 16'h003C);
      readReg(1'b1, 16'h0000);

      repeat (4) @(posedge clk);
      checkOutput("scoreboard_drained", 16'(expQ.size()), 16'h0000);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
